pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RV32 pipeline; sits beside the IF_ID/ID_EX/EX_MEM pipeline registers and the PC.
- Arbitrates three hazard sources and drives every stage's hold and clear enables:
  - load-use data hazard
  - taken branch/jump resolved in EX (control hazard)
  - multi-cycle EX unit (divider) handshake
- Sequences the multi-cycle unit with a start/done handshake and a timeout.

---
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV32 pipeline
// Optional performance counters are built when PERF_CNT_EN is defined.

module pipeline_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_re1,
  input  logic             ID_re2,
  input  logic [4:0]       EX_wr,
  input  logic             EX_is_load,
  input  logic             EX_br_taken,
  input  logic             EX_mc_req,
  input  logic             mc_done,
  output logic             mc_start,
  output logic             stop_PC,
  output logic             stop_IF_ID,
  output logic             stop_ID_EX,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mc_stall_cnt
);

  localparam int TW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MC_TIMEOUT - 1);

  typedef enum logic {RUN, MC_WAIT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            timeout_q, timeout_d;
  logic            load_use;
  logic            start_c, stop_pc_c, stop_ifid_c, stop_idex_c;
  logic            fl_ifid_c, fl_idex_c, fl_exmem_c;

  assign load_use = EX_is_load && (EX_wr != 5'd0) &&
                    ((ID_re1 && (ID_rs1 == EX_wr)) || (ID_re2 && (ID_rs2 == EX_wr)));

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    timeout_d   = timeout_q;
    start_c     = 1'b0;
    stop_pc_c   = 1'b0;
    stop_ifid_c = 1'b0;
    stop_idex_c = 1'b0;
    fl_ifid_c   = 1'b0;
    fl_idex_c   = 1'b0;
    fl_exmem_c  = 1'b0;
    case (state_q)
      RUN: begin
        if (EX_br_taken) begin
          fl_ifid_c = 1'b1;
          fl_idex_c = 1'b1;
        end else if (EX_mc_req) begin
          start_c     = 1'b1;
          stop_pc_c   = 1'b1;
          stop_ifid_c = 1'b1;
          stop_idex_c = 1'b1;
          fl_exmem_c  = 1'b1;
          tcnt_d      = '0;
          state_d     = MC_WAIT;
        end else if (load_use) begin
          stop_pc_c   = 1'b1;
          stop_ifid_c = 1'b1;
          fl_idex_c   = 1'b1;
        end
      end
      MC_WAIT: begin
        // EX is frozen here, so branch/mc_req/load_use inputs are stale and ignored
        tcnt_d = tcnt_q + 1'b1;
        if (mc_done) begin
          state_d = RUN;
        end else if (tcnt_q == T_LAST) begin
          timeout_d = 1'b1;
          state_d   = RUN;
        end else begin
          stop_pc_c   = 1'b1;
          stop_ifid_c = 1'b1;
          stop_idex_c = 1'b1;
          fl_exmem_c  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q   <= RUN;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Reset gates the enables directly so they drop without waiting for a clock
  assign mc_start     = start_c     & ~cpu_rst;
  assign stop_PC      = stop_pc_c   & ~cpu_rst;
  assign stop_IF_ID   = stop_ifid_c & ~cpu_rst;
  assign stop_ID_EX   = stop_idex_c & ~cpu_rst;
  assign flush_IF_ID  = fl_ifid_c   & ~cpu_rst;
  assign flush_ID_EX  = fl_idex_c   & ~cpu_rst;
  assign flush_EX_MEM = fl_exmem_c  & ~cpu_rst;
  assign mc_timeout   = timeout_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic             ld_ev, fl_ev, mc_ev;

  assign ld_ev = (state_q == RUN) && !EX_br_taken && !EX_mc_req && load_use;
  assign fl_ev = (state_q == RUN) && EX_br_taken;
  assign mc_ev = (state_q == MC_WAIT);

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    fl_cnt_d = fl_cnt_q;
    mc_cnt_d = mc_cnt_q;
    if (ld_ev && (ld_cnt_q != '1)) ld_cnt_d = ld_cnt_q + 1'b1;
    if (fl_ev && (fl_cnt_q != '1)) fl_cnt_d = fl_cnt_q + 1'b1;
    if (mc_ev && (mc_cnt_q != '1)) mc_cnt_d = mc_cnt_q + 1'b1;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      ld_cnt_q <= '0;
      fl_cnt_q <= '0;
      mc_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  assign load_stall_cnt = ld_cnt_q;
  assign flush_cnt      = fl_cnt_q;
  assign mc_stall_cnt   = mc_cnt_q;
`else
  assign load_stall_cnt = '0;
  assign flush_cnt      = '0;
  assign mc_stall_cnt   = '0;
`endif

endmodule
